// File: rtl/mm_interrupt_arbiter_if.sv
// ---------------------------------------------------------------------------
// mm_interrupt_arbiter_if
//   Simple memory-mapped register bus used by the interrupt arbiter.
//   master: drives we/addr/data, receives rdata (the CPU side)
//   slave : receives we/addr/data, drives combinational rdata (the arbiter)
// ---------------------------------------------------------------------------
interface mm_interrupt_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output we, output addr, output data, input rdata);
    modport slave  (input we, input addr, input data, output rdata);
endinterface

// File: rtl/mm_interrupt_arbiter.sv
// ---------------------------------------------------------------------------
// mm_interrupt_arbiter
//   Memory-mapped priority interrupt controller. Captures rising edges on
//   i_irq_in into PENDING, masks with ENABLE, dispatches the lowest-index
//   ready source (o_int_pc = its VECTOR, one non-stalled o_int_trigger pulse)
//   and then waits for a software EOI write before dispatching again.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-high
//   i_stall        core stall; o_int_trigger holds while high
//   bus            register bus (slave modport): we/addr/data in, rdata out
//   i_irq_in       peripheral IRQ lines, rising-edge sensitive
//   o_int_pc       handler address of the dispatched source
//   o_int_trigger  interrupt request to the core
//   o_active_id    index of the dispatched source
//   o_busy         high while a source is being fired or serviced
//
// Register map (offset from BASE_ADDR, word aligned)
//   0x00 ENABLE (RW)  0x04 PENDING (R, W1C)  0x08 EOI (W)  0x0C+4*i VECTOR[i]
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no source in service; dispatch when PENDING & ENABLE != 0
// FIRE    | o_int_trigger high, waiting for a non-stalled cycle
// SERVICE | handler running, waiting for an EOI write
// ---------------------------------------------------------------------------
module mm_interrupt_arbiter #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_SRC    = 4,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h9000_0040
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_stall,
    mm_interrupt_arbiter_if.slave bus,
    input  logic [NUM_SRC-1:0]    i_irq_in,
    output logic [DATA_WIDTH-1:0] o_int_pc,
    output logic                  o_int_trigger,
    output logic [2:0]            o_active_id,
    output logic                  o_busy
);

    localparam int WW = DATA_WIDTH - 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FIRE    = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t                r_state;
    logic [NUM_SRC-1:0]    r_enable;
    logic [NUM_SRC-1:0]    r_pending;
    logic [NUM_SRC-1:0]    r_irq_prev;
    logic [DATA_WIDTH-1:0] r_vector [NUM_SRC];
    logic [DATA_WIDTH-1:0] r_int_pc;
    logic                  r_int_trigger;
    logic [2:0]            r_active_id;
    logic                  r_busy;

    // Address decode. Unaligned or out-of-range offsets (including addresses
    // below the base, which wrap to huge offsets) select nothing.
    logic [DATA_WIDTH-1:0] w_off;
    logic                  w_aligned;
    logic [WW-1:0]         w_word;
    logic                  w_sel_enable;
    logic                  w_sel_pending;
    logic                  w_sel_eoi;
    logic [NUM_SRC-1:0]    w_sel_vec;

    assign w_off         = bus.addr - BASE_ADDR;
    assign w_aligned     = (w_off[1:0] == 2'b00);
    assign w_word        = w_off[DATA_WIDTH-1:2];
    assign w_sel_enable  = w_aligned && (w_word == WW'(0));
    assign w_sel_pending = w_aligned && (w_word == WW'(1));
    assign w_sel_eoi     = w_aligned && (w_word == WW'(2));

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_vec_sel
        assign w_sel_vec[g] = w_aligned && (w_word == WW'(3 + g));
    end

    always_comb begin
        bus.rdata = '0;
        if (w_sel_enable) begin
            bus.rdata[NUM_SRC-1:0] = r_enable;
        end else if (w_sel_pending) begin
            bus.rdata[NUM_SRC-1:0] = r_pending;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_sel_vec[i]) bus.rdata = r_vector[i];
            end
        end
    end

    logic [NUM_SRC-1:0]    w_edge;
    logic [NUM_SRC-1:0]    w_req;
    logic [NUM_SRC-1:0]    w_w1c;
    logic [NUM_SRC-1:0]    w_win_onehot;
    logic [NUM_SRC-1:0]    w_dispatch_clr;
    logic [2:0]            w_win_id;
    logic [DATA_WIDTH-1:0] w_win_pc;

    assign w_edge = i_irq_in & ~r_irq_prev;
    assign w_req  = r_pending & r_enable;
    assign w_w1c  = (bus.we && w_sel_pending) ? bus.data[NUM_SRC-1:0] : '0;

    // Descending scan so the lowest ready index wins.
    always_comb begin
        w_win_onehot = '0;
        w_win_id     = '0;
        w_win_pc     = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
                w_win_id        = 3'(i);
                w_win_pc        = r_vector[i];
            end
        end
    end

    assign w_dispatch_clr = (r_state == S_IDLE) ? w_win_onehot : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_enable      <= '0;
            r_pending     <= '0;
            r_irq_prev    <= '0;
            r_int_pc      <= '0;
            r_int_trigger <= 1'b0;
            r_active_id   <= '0;
            r_busy        <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) r_vector[i] <= '0;
        end else begin
            r_irq_prev <= i_irq_in;
            // New edges win over both W1C and the dispatch clear.
            r_pending  <= (r_pending & ~w_w1c & ~w_dispatch_clr) | w_edge;

            if (bus.we && w_sel_enable) r_enable <= bus.data[NUM_SRC-1:0];
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.we && w_sel_vec[i]) r_vector[i] <= bus.data;
            end

            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_state       <= S_FIRE;
                        r_int_pc      <= w_win_pc;
                        r_active_id   <= w_win_id;
                        r_int_trigger <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                S_FIRE: begin
                    if (!i_stall) begin
                        r_state       <= S_SERVICE;
                        r_int_trigger <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    if (bus.we && w_sel_eoi) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_int_trigger <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign o_int_pc      = r_int_pc;
    assign o_int_trigger = r_int_trigger;
    assign o_active_id   = r_active_id;
    assign o_busy        = r_busy;

endmodule
